// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens and the receiver state set.
package tmds_pkg;

   localparam int TMDS_SYM_W = 10;

   localparam logic [TMDS_SYM_W-1:0] TOK_CD00 = 10'h354;
   localparam logic [TMDS_SYM_W-1:0] TOK_CD01 = 10'h0AB;
   localparam logic [TMDS_SYM_W-1:0] TOK_CD10 = 10'h154;
   localparam logic [TMDS_SYM_W-1:0] TOK_CD11 = 10'h2AB;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic       is_token;
      logic [1:0] ctrl;
      logic [7:0] data;
   } sym_dec_t;

endpackage

// File: rtl/tmds_symbol_decoder.sv
// Combinational TMDS 10b symbol decoder: classifies control tokens and undoes the
// transition-minimising data encoding.
module tmds_symbol_decoder
   import tmds_pkg::*;
(
   input  logic [TMDS_SYM_W-1:0] sym,
   output sym_dec_t              dec
);

   logic [7:0] q;

   // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
   always_comb begin
      dec = '0;
      q   = sym[9] ? ~sym[7:0] : sym[7:0];

      dec.data[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         dec.data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end

      case (sym)
         TOK_CD00: begin dec.is_token = 1'b1; dec.ctrl = 2'b00; end
         TOK_CD01: begin dec.is_token = 1'b1; dec.ctrl = 2'b01; end
         TOK_CD10: begin dec.is_token = 1'b1; dec.ctrl = 2'b10; end
         TOK_CD11: begin dec.is_token = 1'b1; dec.ctrl = 2'b11; end
         default:  dec.is_token = 1'b0;
      endcase
   end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: deserialiser, token-based symbol alignment and decode.
// Optional misaligned-token error counter enabled by TMDS_RX_ERRCNT_EN.
module tmds_rx_channel
   import tmds_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int MIS_MAX  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sdata_i,
   output logic       valid_o,
   output logic [7:0] data_o,
   output logic [1:0] ctrl_o,
   output logic       de_o,
   output logic       locked_o
`ifdef TMDS_RX_ERRCNT_EN
   ,
   output logic [15:0] err_cnt_o
`endif
);

   localparam logic [1:0] ST_SEARCH  = SEARCH;
   localparam logic [1:0] ST_CONFIRM = CONFIRM;
   localparam logic [1:0] ST_LOCKED  = LOCKED;

   logic [TMDS_SYM_W-1:0] shreg;
   logic [3:0]            phase, phase_eff, phase_nxt;
   logic [1:0]            state, state_nxt;
   logic [7:0]            lock_cnt, lock_nxt;
   logic [7:0]            mis_cnt, mis_nxt;
   logic                  boundary, tok_hit, emit;
   sym_dec_t              dec;

   tmds_symbol_decoder u_dec (
      .sym (shreg),
      .dec (dec)
   );

   assign tok_hit = dec.is_token;

   // A token seen while searching defines the symbol boundary right here.
   always_comb begin
      phase_eff = phase;
      if (state == ST_SEARCH && tok_hit) phase_eff = 4'd9;
   end

   assign boundary  = (phase_eff == 4'd9);
   assign phase_nxt = boundary ? 4'd0 : phase_eff + 4'd1;

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      mis_nxt   = mis_cnt;
      emit      = 1'b0;
      case (state)
         ST_SEARCH: begin
            if (tok_hit) begin
               state_nxt = ST_CONFIRM;
               lock_nxt  = 8'd1;
            end
         end
         ST_CONFIRM: begin
            if (boundary) begin
               if (!tok_hit) begin
                  state_nxt = ST_SEARCH;
                  lock_nxt  = 8'd0;
               end else if ({1'b0, lock_cnt} + 9'd1 >= 9'(LOCK_CNT)) begin
                  state_nxt = ST_LOCKED;
                  lock_nxt  = lock_cnt + 8'd1;
                  mis_nxt   = 8'd0;
               end else begin
                  lock_nxt  = lock_cnt + 8'd1;
               end
            end
         end
         ST_LOCKED: begin
            if (boundary) begin
               emit = 1'b1;
               if (tok_hit) mis_nxt = 8'd0;
            end else if (tok_hit) begin
               // Losing lock takes priority over any symbol output in the same cycle.
               if ({1'b0, mis_cnt} + 9'd1 >= 9'(MIS_MAX)) begin
                  state_nxt = ST_SEARCH;
                  lock_nxt  = 8'd0;
                  mis_nxt   = 8'd0;
               end else begin
                  mis_nxt   = mis_cnt + 8'd1;
               end
            end
         end
         default: begin
            state_nxt = ST_SEARCH;
            lock_nxt  = 8'd0;
            mis_nxt   = 8'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         phase    <= '0;
         state    <= ST_SEARCH;
         lock_cnt <= '0;
         mis_cnt  <= '0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         ctrl_o   <= '0;
         de_o     <= 1'b0;
         locked_o <= 1'b0;
      end else begin
         shreg    <= {sdata_i, shreg[TMDS_SYM_W-1:1]};
         phase    <= phase_nxt;
         state    <= state_nxt;
         lock_cnt <= lock_nxt;
         mis_cnt  <= mis_nxt;
         valid_o  <= emit;
         locked_o <= (state_nxt == ST_LOCKED);
         if (emit) begin
            de_o <= ~dec.is_token;
            if (dec.is_token) ctrl_o <= dec.ctrl;
            else              data_o <= dec.data;
         end
      end
   end

`ifdef TMDS_RX_ERRCNT_EN
   logic mis_hit;
   assign mis_hit = (state == ST_LOCKED) && tok_hit && !boundary;

   // Survives loss of lock so link quality can be read after a dropout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    err_cnt_o <= '0;
      else if (mis_hit && err_cnt_o != 16'hFFFF)  err_cnt_o <= err_cnt_o + 16'd1;
   end
`else
   // Without the counter, misaligned hits only steer the alignment FSM.
`endif

endmodule

// File: doc/tmds_rx_channel.md
Name: tmds_rx_channel

Overview:
- Receive side of one TMDS lane; the inverse of the encoder + 10:1 serializer in the HDMI transmit path.
- Takes the recovered serial bit stream (LSB of each symbol first) at bit rate on a single clock.
- Deserializes the stream, finds symbol alignment from the control tokens sent during blanking, and decodes 10b symbols back to 8-bit video data or the 2-bit control code.
- One instance per lane (R/G/B); the blue lane's ctrl_o carries {vSync,hSync}.

Parameters:
- LOCK_CNT, 8: consecutive boundary-aligned control tokens required to declare lock (range 2..255).
- MIS_MAX, 4: misaligned token detections tolerated in LOCKED before returning to SEARCH (range 1..255).

Ports:
- clk  in  1  bit-rate clock (one serial bit sampled per rising edge).
- rst  in  1  asynchronous, active-high reset.
- sdata_i  in  1  serial TMDS bit, LSB of each symbol first.
- valid_o  out  1  one-cycle strobe, once per 10 clk while locked; qualifies data_o/ctrl_o/de_o.
- data_o  out  8  decoded pixel byte (meaningful when de_o=1).
- ctrl_o  out  2  decoded control code (meaningful when de_o=0).
- de_o  out  1  1 = data symbol, 0 = control token.
- locked_o  out  1  alignment achieved.

Behaviour:
- Reset (async, active-high): all outputs 0, shift register 0, phase counter 0, state SEARCH, all counters 0.
- Shift register: every clk, shreg <= {sdata_i, shreg[9:1]}. After 10 bits, shreg[0] is the first-received bit.
- Phase counter: mod-10 counter. Boundary = phase==9, meaning shreg holds a full symbol.
- Tokens (shreg value -> ctrl):
  - 10'h354 -> 00
  - 10'h0AB -> 01
  - 10'h154 -> 10
  - 10'h2AB -> 11
  - tok_hit = shreg matches any token.
- State machine, evaluated every clk on the current shreg:
  - SEARCH:
    - tok_hit at any phase -> force phase to 9 for this cycle (restart count), lock_cnt=1, go to CONFIRM.
  - CONFIRM, at each boundary:
    - tok_hit -> lock_cnt++.
    - lock_cnt reaches LOCK_CNT -> LOCKED, locked_o=1 next clk.
    - non-token symbol at a boundary -> SEARCH, lock_cnt=0.
  - LOCKED:
    - Every boundary produces an output symbol.
    - tok_hit at a boundary clears mis_cnt.
    - tok_hit at a non-boundary increments mis_cnt.
    - mis_cnt reaches MIS_MAX -> SEARCH; locked_o=0 and valid_o suppressed from that clk on.
- Decode (registered at the clk after the boundary edge, i.e. 1 clk latency from the edge capturing bit 9):
  - Token symbol: de_o=0, ctrl_o=code, data_o holds its previous value.
  - Otherwise: de_o=1, q = shreg[9] ? ~shreg[7:0] : shreg[7:0].
  - Then d[0]=q[0]; for i=1..7, d[i] = shreg[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
  - data_o=d, ctrl_o holds.
- valid_o: high exactly one clk per symbol, only in LOCKED; never asserted in SEARCH/CONFIRM.
- Simultaneous events:
  - The boundary in the same clk as mis_cnt reaching MIS_MAX: the state change wins and no valid_o is issued.
  - A boundary token in the same clk as a misaligned hit is impossible (same phase); no rule needed.
- Reset mid-symbol: partial symbol discarded, full reacquisition required.

Optional Feature:
- Macro TMDS_RX_ERRCNT_EN.
- Defined: adds output err_cnt_o [15:0].
  - Counts misaligned token detections in LOCKED.
  - Saturates at 16'hFFFF.
  - Cleared only by rst; not cleared by loss of lock.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package tmds_pkg holds:
  - TMDS_SYM_W=10.
  - The four token constants TOK_CD00..TOK_CD11.
  - State enum {SEARCH, CONFIRM, LOCKED}.
  - Shared with a later encoder refactor.
- Sub-module tmds_symbol_decoder: purely combinational, 10b symbol in -> {is_token, ctrl[1:0], data[7:0]}. The top level holds the shift register, phase, FSM and output registers.

Test Plan:
- Serialize 10x 0x354 LSB-first from reset, offset by 3 random leading bits -> locked_o=1 after the 8th aligned token; valid_o strobes every 10 clk; de_o=0, ctrl_o=00.
- After lock, send symbols 0x100 then 0x2FF -> data_o=0x00 then 0xFE, de_o=1, one valid_o each, 1 clk after the boundary.
- Send 0x2AB and 0x154 -> ctrl_o=11 then 10, de_o=0, data_o unchanged.
- Send 5 tokens then 1 data symbol before lock -> returns to SEARCH, locked_o stays 0, no valid_o.
- While locked, slip the stream by 1 bit and send tokens -> after 4 misaligned hits locked_o=0; relocks after 8 more aligned tokens.
- Assert rst mid-symbol -> all outputs 0 immediately (asynchronous); with TMDS_RX_ERRCNT_EN, err_cnt_o=0 after reset and equals 4 after the slip scenario.
